// File: rtl/life_pkg.sv
// life_pkg: shared types, constants and LFSR step for the Game-of-Life engine
package life_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef logic [3:0] ncount_t;
  localparam logic [63:0] LFSR_RESET = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] LFSR_TAPS  = 64'hD800_0000_0000_0000;
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/life_next.sv
// life_next: combinational B3/S23 next-generation computation with optional torus wrap
module life_next #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 0
) (
  input  logic [ROWS*COLS-1:0] i_grid,
  output logic [ROWS*COLS-1:0] o_next
);
  import life_pkg::*;
  // count the eight neighbours of every cell and apply birth-on-3 / survive-on-2-or-3
  always_comb begin
    int rr;
    int cc;
    ncount_t n;
    o_next = '0;
    rr = 0;
    cc = 0;
    n = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        n = '0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (WRAP != 0) begin
                rr = (rr + ROWS) % ROWS;
                cc = (cc + COLS) % COLS;
              end
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                n = n + ncount_t'(i_grid[rr*COLS+cc]);
            end
        o_next[r*COLS+c] = (n == 4'd3) || (i_grid[r*COLS+c] && n == 4'd2);
      end
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: registered Game-of-Life grid with load/randomize/step/run control
module life_engine #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int WRAP           = 0,
  parameter int STOP_ON_STABLE = 1,
  parameter int GEN_W          = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [ROWS*COLS-1:0] i_seed,
  input  logic                 i_randomize,
  input  logic                 i_step,
  input  logic                 i_play,
  output logic [ROWS*COLS-1:0] o_grid,
  output logic [GEN_W-1:0]     o_generation,
  output logic                 o_running,
  output logic                 o_stable,
  output logic                 o_extinct
);
  import life_pkg::*;
  localparam int N = ROWS * COLS;
  logic [N-1:0]     r_grid;
  logic [N-1:0]     w_next;
  logic [N-1:0]     w_rand;
  logic [GEN_W-1:0] r_gen;
  logic [63:0]      r_lfsr;
  state_t           r_state;
  state_t           w_state_nx;
  logic             r_stable;
  logic             r_play_d;
  logic             w_rise;
  logic             w_cmd;
  logic             w_adv;
  logic             w_same;
  logic             w_dead;

  life_next #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_next (
    .i_grid (r_grid),
    .o_next (w_next)
  );

  assign w_rise = i_play & ~r_play_d;
  assign w_cmd  = i_load | i_randomize;
  assign w_adv  = !w_cmd && ((r_state == IDLE) ? i_step : i_play);
  assign w_same = (w_next == r_grid);
  assign w_dead = (w_next == '0);

  // replicate the 64-bit LFSR state across the grid
  always_comb begin
    w_rand = '0;
    for (int i = 0; i < N; i++) w_rand[i] = r_lfsr[i % 64];
  end

  // state register; reset wins over every command
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // next state: commands force IDLE, play edge starts a run, pause or settled grid ends it
  always_comb begin
    w_state_nx = w_cmd ? IDLE :
                 (r_state == IDLE) ? (w_rise ? RUN : IDLE) :
                 !i_play ? IDLE :
                 (STOP_ON_STABLE != 0 && (w_same || w_dead)) ? IDLE : RUN;
  end

  // state-derived outputs
  always_comb begin
    o_running = (r_state == RUN);
  end

  // grid, counter, flag, LFSR and play-edge registers; play is sampled at reset so a held level cannot restart
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_grid   <= '0;
      r_gen    <= '0;
      r_stable <= 1'b0;
      r_lfsr   <= LFSR_RESET;
      r_play_d <= i_play;
    end else begin
      r_lfsr   <= lfsr_next(r_lfsr);
      r_play_d <= i_play;
      if (i_load) begin
        r_grid   <= i_seed;
        r_gen    <= '0;
        r_stable <= 1'b0;
      end else if (i_randomize) begin
        r_grid   <= w_rand;
        r_gen    <= '0;
        r_stable <= 1'b0;
      end else if (w_adv) begin
        r_grid   <= w_next;
        r_gen    <= (&r_gen) ? r_gen : r_gen + 1'b1;
        r_stable <= w_same;
      end
    end
  end

  assign o_grid       = r_grid;
  assign o_generation = r_gen;
  assign o_stable     = r_stable;
  assign o_extinct    = (r_grid == '0);
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: scoreboard bench for life_engine (bounded 8x8 and 2-bit-counter torus instances)
module tb_life_engine;
  logic        clk = 1'b0;
  logic        reset, load, randomize, step, play;
  logic [63:0] seed;
  logic [63:0] g0, g1;
  logic [15:0] gen0;
  logic [1:0]  gen1;
  logic        run0, run1, stab0, stab1, ext0, ext1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    int          d;
    string       name;
    logic [63:0] grid;
    logic [15:0] gen;
    logic        run;
    logic        stab;
    logic        ext;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  localparam logic [63:0] BLK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] RAND  = 64'h0412_6424_0034_3C28;

  life_engine #(.WRAP(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_load(load), .i_seed(seed),
    .i_randomize(randomize), .i_step(step), .i_play(play),
    .o_grid(g0), .o_generation(gen0), .o_running(run0),
    .o_stable(stab0), .o_extinct(ext0)
  );

  life_engine #(.WRAP(1), .GEN_W(2)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_load(load), .i_seed(seed),
    .i_randomize(randomize), .i_step(step), .i_play(play),
    .o_grid(g1), .o_generation(gen1), .o_running(run1),
    .o_stable(stab1), .o_extinct(ext1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int d, input string name, input logic [63:0] grid,
                    input logic [15:0] gen, input logic run, input logic stab, input logic ext);
    exp_t x;
    x.cyc = cyc; x.d = d; x.name = name; x.grid = grid; x.gen = gen;
    x.run = run; x.stab = stab; x.ext = ext;
    sb.push_back(x);
  endtask

  task automatic ex2(input string name, input logic [63:0] grid, input logic [15:0] gen,
                     input logic run, input logic stab, input logic ext);
    ex(0, name, grid, gen, run, stab, ext);
    ex(1, name, grid, gen, run, stab, ext);
  endtask

  task automatic chk(input string name, input int d, input string f,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d %s: got %h expected %h", name, d, f, act, exp);
    end
  endtask

  // monitor: compare every queued expectation once its cycle's outputs have settled
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        chk(e.name, 0, "grid", g0, e.grid);
        chk(e.name, 0, "generation", {48'b0, gen0}, {48'b0, e.gen});
        chk(e.name, 0, "running", {63'b0, run0}, {63'b0, e.run});
        chk(e.name, 0, "stable", {63'b0, stab0}, {63'b0, e.stab});
        chk(e.name, 0, "extinct", {63'b0, ext0}, {63'b0, e.ext});
      end else begin
        chk(e.name, 1, "grid", g1, e.grid);
        chk(e.name, 1, "generation", {48'b0, 14'b0, gen1}, {48'b0, e.gen});
        chk(e.name, 1, "running", {63'b0, run1}, {63'b0, e.run});
        chk(e.name, 1, "stable", {63'b0, stab1}, {63'b0, e.stab});
        chk(e.name, 1, "extinct", {63'b0, ext1}, {63'b0, e.ext});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; load = 1'b0; randomize = 1'b0; step = 1'b0; play = 1'b0; seed = '0;
    go(); go();
    ex2("reset", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1; randomize = 1'b1; play = 1'b1;
    go();
    randomize = 1'b0;
    ex2("rand", RAND, 16'd0, 1'b0, 1'b0, 1'b0);
    go();
    ex2("rand_hold", RAND, 16'd0, 1'b0, 1'b0, 1'b0);
    play = 1'b0;
    go();
    load = 1'b1; seed = BLK_H;
    go();
    load = 1'b0;
    ex2("blink_load", BLK_H, 16'd0, 1'b0, 1'b0, 1'b0);
    step = 1'b1; go(); step = 1'b0;
    ex2("blink_s1", BLK_V, 16'd1, 1'b0, 1'b0, 1'b0);
    step = 1'b1; go(); step = 1'b0;
    ex2("blink_s2", BLK_H, 16'd2, 1'b0, 1'b0, 1'b0);
    load = 1'b1; seed = 64'h83; go(); load = 1'b0;
    step = 1'b1; go(); step = 1'b0;
    ex(0, "edge83", 64'h0, 16'd1, 1'b0, 1'b0, 1'b1);
    ex(1, "torus83", 64'h0100_0000_0000_0101, 16'd1, 1'b0, 1'b0, 1'b0);
    load = 1'b1; seed = 64'h07; go(); load = 1'b0;
    step = 1'b1; go(); step = 1'b0;
    ex(0, "edge07_s1", 64'h0202, 16'd1, 1'b0, 1'b0, 1'b0);
    ex(1, "torus07_s1", 64'h0200_0000_0000_0202, 16'd1, 1'b0, 1'b0, 1'b0);
    step = 1'b1; go(); step = 1'b0;
    ex(0, "edge07_s2", 64'h0, 16'd2, 1'b0, 1'b0, 1'b1);
    ex(1, "torus07_s2", 64'h07, 16'd2, 1'b0, 1'b0, 1'b0);
    load = 1'b1; seed = 64'h0303; go(); load = 1'b0;
    ex2("block_load", 64'h0303, 16'd0, 1'b0, 1'b0, 1'b0);
    play = 1'b1; go();
    ex2("block_run", 64'h0303, 16'd0, 1'b1, 1'b0, 1'b0);
    go();
    ex2("block_stop", 64'h0303, 16'd1, 1'b0, 1'b1, 1'b0);
    go();
    ex2("block_idle", 64'h0303, 16'd1, 1'b0, 1'b1, 1'b0);
    play = 1'b0; go();
    load = 1'b1; step = 1'b1; seed = BLK_H; go(); load = 1'b0; step = 1'b0;
    ex2("prio_load_step", BLK_H, 16'd0, 1'b0, 1'b0, 1'b0);
    play = 1'b1; go();
    ex2("run_start", BLK_H, 16'd0, 1'b1, 1'b0, 1'b0);
    go(); go(); go(); go();
    ex(0, "run4", BLK_H, 16'd4, 1'b1, 1'b0, 1'b0);
    ex(1, "run4_sat", BLK_H, 16'd3, 1'b1, 1'b0, 1'b0);
    reset = 1'b0; go(); reset = 1'b1;
    ex2("mid_reset", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    go(); go();
    ex2("no_restart", 64'h0, 16'd0, 1'b0, 1'b0, 1'b1);
    play = 1'b0; go(); go();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
